// File: rtl/color_transform.sv
// ---------------------------------------------------------------------------
// color_transform
//
// Streaming RGB-to-greyscale converter, the first stage of the image
// pipeline. It takes one 24-bit RGB pixel per cycle over a valid/busy
// handshake and emits one greyscale pixel {Y,Y,Y} per accepted input, in
// order.
//
//   Y = (77*R + 150*G + 29*B + RND) >> 8
//
// The weights sum to 256, so Y never exceeds 255 and no saturation is needed.
//
// The datapath is a two-stage elastic pipeline:
//   S1 holds the three weighted products and a valid bit.
//   S2 holds the summed, shifted luminance and drives the output directly.
//
// Configuration macro:
//   COLORTRANSFORM_ROUND_EN  defined   -> RND = 128 (round to nearest)
//                            undefined -> RND = 0   (truncate)
//
// Ports:
//   i_clk        in   1   sole clock, rising edge
//   i_rst        in   1   synchronous active-high reset
//   i_rgb_busy   out  1   1 = input pixel not accepted this cycle
//   i_rgb_vld    in   1   input pixel valid
//   i_rgb_data   in  24   input pixel, R=[7:0] G=[15:8] B=[23:16]
//   o_grey_busy  in   1   1 = downstream does not take the output this cycle
//   o_grey_vld   out  1   output pixel valid
//   o_grey_data  out 24   grey pixel {Y,Y,Y}
// ---------------------------------------------------------------------------
module color_transform (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        i_rgb_busy,
  input  logic        i_rgb_vld,
  input  logic [23:0] i_rgb_data,
  input  logic        o_grey_busy,
  output logic        o_grey_vld,
  output logic [23:0] o_grey_data
);

`ifdef COLORTRANSFORM_ROUND_EN
  localparam logic [16:0] RND = 17'd128;
`else
  localparam logic [16:0] RND = 17'd0;
`endif

  logic        s1_vld;
  logic [15:0] r_prod;
  logic [15:0] g_prod;
  logic [15:0] b_prod;
  logic        s2_vld;
  logic [7:0]  y_reg;

  logic        s2_ready;
  logic        s1_ready;
  logic [16:0] sum;
  logic [7:0]  y_next;

  // S2 can accept new contents when it is empty or its pixel leaves this
  // edge; S1 can accept when it is empty or it moves into S2. Chaining the
  // two lets take, advance and load all happen on the same edge.
  assign s2_ready = !s2_vld || !o_grey_busy;
  assign s1_ready = !s1_vld || s2_ready;

  // 17-bit sum of the registered products; the shift by 8 is a plain
  // truncation of the low byte.
  assign sum    = {1'b0, r_prod} + {1'b0, g_prod} + {1'b0, b_prod} + RND;
  assign y_next = 8'(sum >> 8);

  // Input is refused only when both stages are full and the output is
  // stalled, and always while reset is held.
  assign i_rgb_busy = i_rst | (s1_vld & s2_vld & o_grey_busy);

  assign o_grey_vld  = s2_vld;
  assign o_grey_data = {y_reg, y_reg, y_reg};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_vld <= 1'b0;
      r_prod <= 16'd0;
      g_prod <= 16'd0;
      b_prod <= 16'd0;
      s2_vld <= 1'b0;
      y_reg  <= 8'd0;
    end else begin
      // S2 data only changes when a real pixel arrives from S1, so the
      // output stays stable while it is held under backpressure.
      if (s2_ready) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          y_reg <= y_next;
        end
      end
      if (s1_ready) begin
        s1_vld <= i_rgb_vld;
        if (i_rgb_vld) begin
          r_prod <= {8'd0, i_rgb_data[7:0]}   * 16'd77;
          g_prod <= {8'd0, i_rgb_data[15:8]}  * 16'd150;
          b_prod <= {8'd0, i_rgb_data[23:16]} * 16'd29;
        end
      end
    end
  end

endmodule

// File: tb/tb_color_transform.sv
// ---------------------------------------------------------------------------
// tb_color_transform
//
// Self-checking bench for color_transform. Expected grey pixels are computed
// from the luminance formula and pushed to a scoreboard queue when an input
// transfer is seen; they are popped and compared when an output transfer is
// seen. Input busy is checked against the scoreboard occupancy.
// ---------------------------------------------------------------------------
module tb_color_transform;

`ifdef COLORTRANSFORM_ROUND_EN
  localparam int RND = 128;
`else
  localparam int RND = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rgbBusy;
  logic        rgbVld = 1'b0;
  logic [23:0] rgbData = 24'd0;
  logic        greyBusy = 1'b0;
  logic        greyVld;
  logic [23:0] greyData;

  int          total = 0;
  int          bad = 0;
  logic [23:0] sb[$];

  always #5 clk = ~clk;

  color_transform dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rgb_busy  (rgbBusy),
    .i_rgb_vld   (rgbVld),
    .i_rgb_data  (rgbData),
    .o_grey_busy (greyBusy),
    .o_grey_vld  (greyVld),
    .o_grey_data (greyData)
  );

  // Reference luminance straight from the formula, with Y in every channel.
  function automatic logic [23:0] refGrey(input logic [23:0] p);
    int y;
    y = (77 * int'(p[7:0]) + 150 * int'(p[15:8]) + 29 * int'(p[23:16]) + RND) / 256;
    return {y[7:0], y[7:0], y[7:0]};
  endfunction

  // Advance one cycle: sample the DUT on the falling edge, push the expected
  // result for an accepted input, then step past the rising edge.
  task automatic tick(output int occ, output logic ib, output logic ovld,
                      output logic took, output logic [23:0] od);
    @(negedge clk);
    occ  = sb.size();
    ib   = rgbBusy;
    ovld = greyVld;
    took = greyVld && !greyBusy;
    od   = greyData;
    if (rgbVld && !rgbBusy) sb.push_back(refGrey(rgbData));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] popExp();
    logic [23:0] e;
    if (sb.size() != 0) e = sb.pop_front();
    else e = 'x;
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1; rgbVld = 1'b0; greyBusy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (greyVld !== 1'b0) begin bad++; $display("[TB] FAIL reset_vld: got %b want 0", greyVld); end
      total++;
      if (greyData !== 24'h0) begin bad++; $display("[TB] FAIL reset_data: got %h want 000000", greyData); end
      total++;
      if (rgbBusy !== 1'b1) begin bad++; $display("[TB] FAIL reset_busy: got %b want 1", rgbBusy); end
      @(posedge clk);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (rgbBusy !== 1'b0) begin bad++; $display("[TB] FAIL release_busy: got %b want 0", rgbBusy); end
    @(posedge clk);
    #1;
    sb.delete();
  endtask

  task automatic test_colors();
    logic [23:0] pix [5];
    logic [23:0] want [5];
    int occ; logic ib, ovld, took; logic [23:0] od, e;
    int lat; logic got;
    pix[0] = 24'hFFFFFF; want[0] = 24'hFFFFFF;
    pix[1] = 24'h0000FF; want[1] = (RND != 0) ? 24'h4D4D4D : 24'h4C4C4C;
    pix[2] = 24'h00FF00; want[2] = 24'h959595;
    pix[3] = 24'hFF0000; want[3] = (RND != 0) ? 24'h1D1D1D : 24'h1C1C1C;
    pix[4] = 24'h000000; want[4] = 24'h000000;
    greyBusy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rgbVld = 1'b1; rgbData = pix[i];
      tick(occ, ib, ovld, took, od);
      total++;
      if (ib !== 1'b0) begin bad++; $display("[TB] FAIL color%0d_accept: busy got %b want 0", i, ib); end
      rgbVld = 1'b0;
      lat = 0; got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        tick(occ, ib, ovld, took, od);
        lat++;
        if (took) begin
          got = 1'b1;
          e = popExp();
          total++;
          if (od !== want[i]) begin bad++; $display("[TB] FAIL color%0d: got %h want %h", i, od, want[i]); end
          total++;
          if (od !== e) begin bad++; $display("[TB] FAIL color%0d_model: got %h want %h", i, od, e); end
          total++;
          if (lat != 2) begin bad++; $display("[TB] FAIL color%0d_latency: got %0d want 2", i, lat); end
        end
      end
      if (!got) begin total++; bad++; $display("[TB] FAIL color%0d_timeout: got no output want one", i); end
    end
  endtask

  task automatic test_back_to_back();
    int occ; logic ib, ovld, took; logic [23:0] od, e;
    int sent, recv, cyc, firstIn, firstOut;
    sent = 0; recv = 0; cyc = 0; firstIn = -1; firstOut = -1;
    greyBusy = 1'b0;
    while (recv < 100 && cyc < 400) begin
      rgbVld = (sent < 100); rgbData = $urandom;
      tick(occ, ib, ovld, took, od);
      if (rgbVld && !ib) begin
        if (sent == 0) firstIn = cyc;
        sent++;
      end
      if (took) begin
        if (firstOut < 0) firstOut = cyc;
        e = popExp();
        total++;
        if (od !== e) begin bad++; $display("[TB] FAIL stream%0d: got %h want %h", recv, od, e); end
        recv++;
      end
      cyc++;
    end
    rgbVld = 1'b0;
    total++;
    if (recv != 100) begin bad++; $display("[TB] FAIL stream_count: got %0d want 100", recv); end
    total++;
    if (firstOut - firstIn != 2) begin bad++; $display("[TB] FAIL stream_latency: got %0d want 2", firstOut - firstIn); end
    total++;
    if (cyc != 102) begin bad++; $display("[TB] FAIL stream_rate: got %0d cycles want 102", cyc); end
  endtask

  task automatic test_backpressure();
    int occ; logic ib, ovld, took; logic [23:0] od, e, held;
    int sent, recv, cyc; logic prevHold, sawBusy, expBusy;
    sent = 0; recv = 0; cyc = 0; prevHold = 1'b0; sawBusy = 1'b0; held = '0;
    while (recv < 20 && cyc < 200) begin
      rgbVld = (sent < 20); rgbData = $urandom;
      greyBusy = (cyc >= 4 && cyc < 9);
      tick(occ, ib, ovld, took, od);
      expBusy = (occ == 2) && greyBusy;
      total++;
      if (ib !== expBusy) begin bad++; $display("[TB] FAIL bp_busy cyc%0d: got %b want %b", cyc, ib, expBusy); end
      if (ib) sawBusy = 1'b1;
      if (prevHold) begin
        total++;
        if (od !== held) begin bad++; $display("[TB] FAIL bp_stable cyc%0d: got %h want %h", cyc, od, held); end
      end
      prevHold = ovld && greyBusy;
      held = od;
      if (rgbVld && !ib) sent++;
      if (took) begin
        e = popExp();
        total++;
        if (od !== e) begin bad++; $display("[TB] FAIL bp_data%0d: got %h want %h", recv, od, e); end
        recv++;
      end
      cyc++;
    end
    rgbVld = 1'b0; greyBusy = 1'b0;
    total++;
    if (recv != 20) begin bad++; $display("[TB] FAIL bp_count: got %0d want 20", recv); end
    total++;
    if (sawBusy !== 1'b1) begin bad++; $display("[TB] FAIL bp_busy_rise: got %b want 1", sawBusy); end
  endtask

  task automatic test_random();
    int occ; logic ib, ovld, took; logic [23:0] od, e;
    int sent, recv, cyc; logic expBusy;
    sent = 0; recv = 0; cyc = 0;
    while (recv < 1000 && cyc < 20000) begin
      rgbVld = (sent < 1000) && ($urandom_range(1) == 1);
      rgbData = $urandom;
      greyBusy = ($urandom_range(1) == 1);
      tick(occ, ib, ovld, took, od);
      expBusy = (occ == 2) && greyBusy;
      total++;
      if (ib !== expBusy) begin bad++; $display("[TB] FAIL rand_busy cyc%0d: got %b want %b", cyc, ib, expBusy); end
      if (rgbVld && !ib) sent++;
      if (took) begin
        e = popExp();
        total++;
        if (od !== e) begin bad++; $display("[TB] FAIL rand_data%0d: got %h want %h", recv, od, e); end
        recv++;
      end
      cyc++;
    end
    rgbVld = 1'b0; greyBusy = 1'b0;
    total++;
    if (recv != 1000) begin bad++; $display("[TB] FAIL rand_count: got %0d want 1000", recv); end
  endtask

  task automatic test_reset_midstream();
    int occ; logic ib, ovld, took; logic [23:0] od, e;
    int lat; logic got;
    // Park two pixels in the pipeline, then reset over them.
    greyBusy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rgbVld = 1'b1; rgbData = $urandom;
      tick(occ, ib, ovld, took, od);
    end
    rgbVld = 1'b0;
    total++;
    if (sb.size() != 2) begin bad++; $display("[TB] FAIL mid_inflight: got %0d want 2", sb.size()); end
    rst = 1'b1;
    tick(occ, ib, ovld, took, od);
    rst = 1'b0;
    sb.delete();
    greyBusy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(occ, ib, ovld, took, od);
      total++;
      if (ovld !== 1'b0) begin bad++; $display("[TB] FAIL mid_flush cyc%0d: got vld %b want 0", i, ovld); end
    end
    rgbVld = 1'b1; rgbData = 24'h3C7A19;
    tick(occ, ib, ovld, took, od);
    rgbVld = 1'b0;
    lat = 0; got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick(occ, ib, ovld, took, od);
      lat++;
      if (took) begin
        got = 1'b1;
        e = popExp();
        total++;
        if (od !== refGrey(24'h3C7A19)) begin bad++; $display("[TB] FAIL mid_first: got %h want %h", od, refGrey(24'h3C7A19)); end
        total++;
        if (e !== refGrey(24'h3C7A19)) begin bad++; $display("[TB] FAIL mid_order: got %h want %h", e, refGrey(24'h3C7A19)); end
        total++;
        if (lat != 2) begin bad++; $display("[TB] FAIL mid_latency: got %0d want 2", lat); end
      end
    end
    if (!got) begin total++; bad++; $display("[TB] FAIL mid_timeout: got no output want one"); end
  endtask

  initial begin
    test_reset();
    test_colors();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
